// File: rtl/priority_arbiter.sv
// priority_arbiter: registered fixed-priority / round-robin arbiter presenting one grant at a time over valid/ready
module priority_arbiter #(
  parameter int N = 4,
  parameter int MODE = 0,
  localparam int ID_W = (N > 2) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req,
  input  logic            ready,
  output logic            valid,
  output logic [ID_W-1:0] grant_id,
  output logic [N-1:0]    grant_onehot
);
  localparam logic [ID_W:0] L_N = (ID_W+1)'(N);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t r_state;
  logic r_arm;
  logic [ID_W-1:0] r_id, r_ptr, w_ptr_next, w_win_id, w_off;
  logic [ID_W:0] w_sum;
  logic [N-1:0] r_oh, w_rot;
  logic w_hs, w_any, w_load;
  assign w_hs = (r_state == GRANT) && ready;
  assign w_any = |req;
  // r_arm holds off the first grant until one full clock after reset release
  assign w_load = r_arm && ((r_state == IDLE) || ready);
  assign w_ptr_next = (MODE == 0) ? '0 : !w_hs ? r_ptr : (r_id == ID_W'(N - 1)) ? '0 : r_id + ID_W'(1);
  assign w_rot = N'({req, req} >> w_ptr_next);
  assign w_sum = {1'b0, w_ptr_next} + {1'b0, w_off};
  always_comb begin
    w_off = '0;
    for (int j = N - 1; j >= 0; j--) if (w_rot[j]) w_off = ID_W'(j);
  end
  always_comb begin
    w_win_id = (w_sum >= L_N) ? ID_W'(w_sum - L_N) : ID_W'(w_sum);
    if (MODE == 0)
      for (int i = 0; i < N; i++) if (req[i]) w_win_id = ID_W'(i);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_arm <= 1'b0;
      r_id <= '0;
      r_oh <= '0;
      r_ptr <= '0;
    end else begin
      r_arm <= 1'b1;
      r_ptr <= w_ptr_next;
      if (w_load) begin
        r_state <= w_any ? GRANT : IDLE;
        r_id <= w_any ? w_win_id : '0;
        r_oh <= w_any ? (N'(1) << w_win_id) : '0;
      end
    end
  end
  assign valid = (r_state == GRANT);
  assign grant_id = r_id;
  assign grant_onehot = r_oh;
endmodule

// File: tb/tb_priority_arbiter.sv
// tb_priority_arbiter: eight arbiter configurations checked against a behavioural model plus directed scenarios
module tb_priority_arbiter;
  localparam int CN [8] = '{4, 4, 5, 2, 2, 5, 8, 8};
  localparam int CM [8] = '{0, 1, 1, 0, 1, 0, 0, 1};
  logic clk = 1'b0;
  logic [7:0] req_a [8];
  logic rdy_a [8];
  logic rst_a [8];
  logic valid_a [8];
  logic [2:0] gid_a [8];
  logic [7:0] goh_a [8];
  logic [2:0] ptr_a [8];
  bit chk_en = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  // winner by the arbitration rules: highest set bit, or first set bit scanning up from p with wrap
  function automatic int winner(input logic [7:0] r, input int p, input int m, input int n);
    if (m == 0) begin
      for (int i = n - 1; i >= 0; i--) if (r[i]) return i;
    end else begin
      for (int k = 0; k < n; k++) if (r[(p + k) % n]) return (p + k) % n;
    end
    return -1;
  endfunction
  for (genvar g = 0; g < 8; g++) begin : u
    localparam int n = CN[g];
    localparam int w = (n > 2) ? $clog2(n) : 1;
    logic v;
    logic [w-1:0] id;
    logic [n-1:0] oh;
    int mv = 0, mid = 0, mptr = 0, pn, win, pid = 0;
    bit marm = 1'b0, mhold = 1'b0;
    priority_arbiter #(.N(n), .MODE(CM[g])) dut (
      .clk(clk), .rst_n(rst_a[g]), .req(req_a[g][n-1:0]), .ready(rdy_a[g]),
      .valid(v), .grant_id(id), .grant_onehot(oh)
    );
    assign valid_a[g] = v;
    assign gid_a[g] = 3'(id);
    assign goh_a[g] = 8'(oh);
    assign ptr_a[g] = 3'(dut.r_ptr);
    always_comb begin
      pn = (CM[g] == 0) ? 0 : (mv != 0 && rdy_a[g]) ? (mid + 1) % n : mptr;
      win = winner(req_a[g], pn, CM[g], n);
    end
    always @(posedge clk or negedge rst_a[g]) begin
      if (!rst_a[g]) begin
        mv <= 0; mid <= 0; mptr <= 0; marm <= 1'b0; mhold <= 1'b0;
      end else begin
        mhold <= (mv != 0) && !rdy_a[g];
        mptr <= pn;
        marm <= 1'b1;
        if (marm && (mv == 0 || rdy_a[g])) begin
          mv <= int'(win >= 0);
          mid <= (win >= 0) ? win : 0;
        end
      end
    end
    always @(negedge clk) begin
      if (chk_en) begin
        check($sformatf("c%0d valid", g), int'(v), mv);
        check($sformatf("c%0d grant_id", g), int'(id), mid);
        check($sformatf("c%0d grant_onehot", g), int'(oh), (mv != 0) ? (1 << mid) : 0);
        check($sformatf("c%0d ptr", g), int'(dut.r_ptr), mptr);
        if (v) check($sformatf("c%0d onehot_of_id", g), int'(oh), 1 << id);
        if (mhold) check($sformatf("c%0d hold_id", g), int'(id), pid);
        pid <= int'(id);
      end
    end
  end
  task automatic nxt;
    @(negedge clk);
    #1;
  endtask
  initial begin
    foreach (req_a[g]) begin
      req_a[g] = '0; rdy_a[g] = 1'b0; rst_a[g] = 1'b1;
    end
    #2;
    foreach (rst_a[g]) rst_a[g] = 1'b0;
    nxt;
    nxt;
    for (int g = 0; g < 8; g++) begin
      check("reset valid", int'(valid_a[g]), 0);
      check("reset grant_id", int'(gid_a[g]), 0);
      check("reset onehot", int'(goh_a[g]), 0);
      check("reset ptr", int'(ptr_a[g]), 0);
    end
    req_a[1] = 8'hF;
    foreach (rst_a[g]) rst_a[g] = 1'b1;
    chk_en = 1'b1;
    nxt;
    check("no grant at first edge", int'(valid_a[1]), 0);
    rdy_a[0] = 1'b1;
    req_a[0] = 8'b0101;
    nxt;
    check("fixed valid", int'(valid_a[0]), 1);
    check("fixed grant_id", int'(gid_a[0]), 2);
    check("fixed onehot", int'(goh_a[0]), 4);
    check("rr first valid", int'(valid_a[1]), 1);
    check("rr first grant_id", int'(gid_a[1]), 0);
    req_a[0] = '0;
    rdy_a[1] = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      nxt;
      if (k == 1) begin
        check("fixed idle valid", int'(valid_a[0]), 0);
        check("fixed idle onehot", int'(goh_a[0]), 0);
      end
      check("rr valid", int'(valid_a[1]), 1);
      check("rr grant_id", int'(gid_a[1]), k % 4);
    end
    rdy_a[1] = 1'b0;
    req_a[1] = 8'b1000;
    for (int k = 0; k < 3; k++) begin
      nxt;
      check("stall valid", int'(valid_a[1]), 1);
      check("stall grant_id", int'(gid_a[1]), 1);
      req_a[1] = '0;
    end
    rdy_a[1] = 1'b1;
    nxt;
    check("stall release valid", int'(valid_a[1]), 0);
    check("stall release onehot", int'(goh_a[1]), 0);
    check("stall release ptr", int'(ptr_a[1]), 2);
    rdy_a[2] = 1'b1;
    req_a[2] = 8'b10001;
    for (int k = 0; k < 4; k++) begin
      nxt;
      check("wrap5 valid", int'(valid_a[2]), 1);
      check("wrap5 grant_id", int'(gid_a[2]), (k % 2 == 1) ? 4 : 0);
    end
    req_a[2] = '0;
    rdy_a[1] = 1'b0;
    req_a[1] = 8'b0100;
    nxt;
    check("pre-reset valid", int'(valid_a[1]), 1);
    check("pre-reset grant_id", int'(gid_a[1]), 2);
    rst_a[1] = 1'b0;
    #1;
    check("async reset valid", int'(valid_a[1]), 0);
    check("async reset grant_id", int'(gid_a[1]), 0);
    check("async reset onehot", int'(goh_a[1]), 0);
    check("async reset ptr", int'(ptr_a[1]), 0);
    rst_a[1] = 1'b1;
    req_a[1] = 8'hF;
    rdy_a[1] = 1'b1;
    nxt;
    check("post-reset first edge valid", int'(valid_a[1]), 0);
    nxt;
    check("post-reset valid", int'(valid_a[1]), 1);
    check("post-reset grant_id", int'(gid_a[1]), 0);
    repeat (1000) begin
      for (int g = 0; g < 8; g++) begin
        req_a[g] = ($urandom % 6 == 0) ? 8'h0 : 8'($urandom) & 8'((1 << CN[g]) - 1);
        rdy_a[g] = ($urandom % 3 != 0);
      end
      nxt;
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
